count_uart_tx: RTL and testbench
================================

# count_uart_tx

Serial output stage for the 8-bit counter. Accepts the counter value over a valid/ready handshake into a one-entry holding register and shifts it out on a single pin as 8N1 UART frames (1 start, 8 data LSB-first, 1 stop). A byte can be queued in the holding register while another byte is shifting, so back-to-back frames go out with no idle gap. Sits directly downstream of the counter: its `data_in` is driven by the counter output bus.

## Interface

- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200). Legal range 2..65535; values outside that range are a configuration error.
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset, sampled on rising `clk`.
- `data_in`  in  8  byte to transmit, normally the counter value.
- `data_valid`  in  1  upstream has a byte on `data_in`.
- `data_ready`  out  1  holding register empty. Equals `!hold_full`, a direct register output.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  `state != IDLE || hold_full`.

## Operation

- Reset values: `tx`=1, `data_ready`=1, `busy`=0, state=IDLE, `hold_full`=0, baud counter=0, bit index=0.
- Accept: on a rising edge where `data_valid && data_ready`, the block captures `data_in` into `hold` and sets `hold_full`. While `data_ready`=0, `data_valid` and `data_in` are ignored.
- Load: when state is IDLE (or at the last cycle of STOP) and `hold_full`=1, the next edge copies `hold` into the shifter, clears `hold_full` and enters START. Accept and load never coincide, because `data_ready` is low whenever `hold_full`=1.
- FSM states and transitions:
  - IDLE: `tx`=1. Go to START when `hold_full`=1.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shifter[bit index] for `CLKS_PER_BIT` cycles per bit. Bit index runs 0→7. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle, go to START (loading from `hold`) if `hold_full`=1, otherwise go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1, with width $clog2(`CLKS_PER_BIT`). It clears on every state entry and on every bit advance. The terminal count is `CLKS_PER_BIT`-1; the counter never wraps past it.
- Data is sent LSB first. Value wrap (0xFF followed by 0x00) needs no special handling.
- Reset mid-frame: the frame is aborted. On the reset edge `tx` returns to 1, the queued byte is discarded, and outputs return to their reset values.

## Timing

- Accept at edge E0 from IDLE:
  - E1: `tx` falls (start bit). `hold_full` clears, so `data_ready` returns to 1 after E1.
  - Latency from accept to start bit is 1 cycle.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: the STOP bit of frame N is followed immediately by the START bit of frame N+1. Steady-state throughput is one byte per 10×`CLKS_PER_BIT` cycles.
- `busy` falls on the edge that moves the FSM from STOP to IDLE with `hold_full`=0.

## Structure

- Shared package `count_uart_pkg`:
  - state enum (IDLE, START, DATA, STOP), 2 bits;
  - `DATA_BITS`=8;
  - start bit level 0, stop bit level 1.
- Sub-module `count_uart_baud`: bit-period counter.
  - Inputs: `clk`, `rst`, `restart`.
  - Output: `bit_done`, a one-cycle pulse at the terminal count.
  - Parameterised by `CLKS_PER_BIT`.
- Top level holds the holding register, the shifter, the bit index and the FSM.

## Test plan

- Reset: hold `rst`=1 for 3 cycles with `data_valid`=1 → `tx`=1, `data_ready`=1, `busy`=0 throughout. No byte is accepted.
- Single byte, `CLKS_PER_BIT`=4, `data_in`=0xA5 for one cycle → `tx` low 1 cycle after accept for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. `busy` is high for 41 cycles from accept.
- Back-to-back, `CLKS_PER_BIT`=4, 0x00 then 0xFF with `data_valid` held high:
  - 0xFF is accepted 2 cycles after 0x00;
  - `tx` shows 80 contiguous frame cycles with no idle high gap between stop and start.
- Valid while full: queue 0x3C during a frame, then keep `data_valid`=1 with `data_in` changing every cycle → only 0x3C follows. The next accept happens only after the 0x3C load.
- Reset mid-frame during data bit 3, with a byte queued → `tx`=1 and `data_ready`=1 after the reset edge. No further frames are sent, and the queued byte is dropped.
- Minimum period, `CLKS_PER_BIT`=2, `data_in`=0x80 → a 20-cycle frame. Data bit 7 is high for cycles 16–17, and the stop bit is high for cycles 18–19.

Source files
------------

// File: rtl/count_uart_pkg.sv
// count_uart_pkg: shared types and constants for the counter UART transmitter.
package count_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/count_uart_if.sv
// count_uart_if: valid/ready byte handshake from the counter into the transmitter.
interface count_uart_if;
    import count_uart_pkg::*;
    logic [DATA_BITS-1:0] data_in;
    logic data_valid;
    logic data_ready;
    modport master(output data_in, data_valid, input data_ready);
    modport slave(input data_in, data_valid, output data_ready);
endinterface

// File: rtl/count_uart_baud.sv
// count_uart_baud: bit-period counter, pulses bit_done on the last cycle of each bit.
module count_uart_baud #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    assign bit_done = cnt == LAST;
    always_ff @(posedge clk) begin
        if (rst || restart || bit_done) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/count_uart_tx.sv
// count_uart_tx: one-entry holding register feeding an 8N1 UART shifter.
module count_uart_tx
    import count_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    count_uart_if.slave bus,
    output logic tx,
    output logic busy
);
    localparam int IW = $clog2(DATA_BITS);
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cfg
        $error("count_uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
    state_t state;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] shifter;
    logic hold_full;
    logic [IW-1:0] bit_idx;
    logic bit_done;
    count_uart_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk(clk),
        .rst(rst),
        .restart(state == IDLE),
        .bit_done(bit_done)
    );
    assign bus.data_ready = !hold_full;
    assign busy = state != IDLE || hold_full;
    // Accept only fires with hold empty and load only with hold full, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hold <= '0;
            hold_full <= 1'b0;
            shifter <= '0;
            bit_idx <= '0;
            tx <= STOP_BIT;
        end else begin
            if (bus.data_valid && !hold_full) begin
                hold <= bus.data_in;
                hold_full <= 1'b1;
            end
            case (state)
                IDLE: if (hold_full) begin
                    shifter <= hold;
                    hold_full <= 1'b0;
                    state <= START;
                    tx <= START_BIT;
                end
                START: if (bit_done) begin
                    state <= DATA;
                    bit_idx <= '0;
                    tx <= shifter[0];
                end
                DATA: if (bit_done) begin
                    if (bit_idx == IW'(DATA_BITS - 1)) begin
                        state <= STOP;
                        tx <= STOP_BIT;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        tx <= shifter[bit_idx + 1'b1];
                    end
                end
                STOP: if (bit_done) begin
                    state <= hold_full ? START : IDLE;
                    if (hold_full) begin
                        shifter <= hold;
                        hold_full <= 1'b0;
                        tx <= START_BIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_count_uart_tx.sv
// tb_count_uart_tx: scoreboard bench; a frame-level timing model predicts every byte and line state.
module tb_count_uart_tx;
    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;
    typedef struct {
        logic [7:0] data;
        int start;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, busy, tx2, busy2;
    always #5 clk = ~clk;

    count_uart_if bus ();
    count_uart_if bus2 ();
    count_uart_tx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus), .tx(tx), .busy(busy));
    count_uart_tx #(.CLKS_PER_BIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .tx(tx2), .busy(busy2));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int free_at = 0;
    int pend_start = 0;
    int acc_cyc = 0;
    bit mon_en = 1'b0;
    frame_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int k, input int cpb);
        int i;
        i = k / cpb;
        return i == 0 ? 1'b0 : i == 9 ? 1'b1 : d[i-1];
    endfunction

    // Line model: a byte accepted at edge n starts at max(n+1, end of the previous frame).
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, output logic acc);
        int t;
        int n;
        int s;
        t = cyc;
        check("data_ready", bus.data_ready, t >= pend_start);
        check("busy", busy, t < free_at);
        bus.data_valid = v;
        bus.data_in = d;
        rst = r;
        acc = 1'b0;
        if (r) begin
            pend_start = 0;
            free_at = 0;
            sb.delete();
        end else if (v && t >= pend_start) begin
            n = t + 1;
            s = (n + 1 > free_at) ? n + 1 : free_at;
            sb.push_back('{d, s});
            pend_start = s;
            free_at = s + FRAME;
            acc = 1'b1;
            acc_cyc = n;
        end
        @(negedge clk);
    endtask

    initial begin : monitor
        frame_t f;
        int bad;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with empty scoreboard", cyc);
                    repeat (FRAME - 1) @(negedge clk);
                end else begin
                    f = sb.pop_front();
                    bad = 0;
                    got = 8'h00;
                    check("frame_start", cyc, f.start);
                    for (int k = 0; k < FRAME; k++) begin
                        if (k > 0) @(negedge clk);
                        if (!mon_en) break;
                        if (tx !== exp_bit(f.data, k, CPB)) bad++;
                        if (k / CPB >= 1 && k / CPB <= 8 && k % CPB == CPB / 2) got[k/CPB-1] = tx;
                    end
                    if (mon_en) begin
                        check("frame_data", got, f.data);
                        check("frame_bad_cycles", bad, 0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int first;
        int s;
        int bad;
        logic [19:0] got2;
        logic [19:0] exp2;
        bus.data_valid = 1'b1;
        bus.data_in = 8'h5A;
        bus2.data_valid = 1'b0;
        bus2.data_in = 8'h00;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_tx", tx, 1'b1);
            cycle(1'b1, 8'h5A, 1'b1, a);
        end
        cycle(1'b0, 8'h00, 1'b0, a);
        check("post_reset_tx", tx, 1'b1);
        mon_en = 1'b1;
        // single byte
        cycle(1'b1, 8'hA5, 1'b0, a);
        repeat (45) cycle(1'b0, 8'h00, 1'b0, a);
        // back-to-back with valid held high
        cycle(1'b1, 8'h00, 1'b0, a);
        first = acc_cyc;
        for (int i = 0; i < 10 && !a; i++) cycle(1'b1, 8'h00, 1'b0, a);
        a = 1'b0;
        for (int i = 0; i < 10 && !a; i++) cycle(1'b1, 8'hFF, 1'b0, a);
        check("b2b_accept_gap", acc_cyc - first, 2);
        repeat (90) cycle(1'b0, 8'h00, 1'b0, a);
        // valid held while full, data changing every cycle
        cycle(1'b1, 8'h11, 1'b0, a);
        repeat (5) cycle(1'b0, 8'h00, 1'b0, a);
        cycle(1'b1, 8'h3C, 1'b0, a);
        repeat (30) cycle(1'b1, 8'($urandom), 1'b0, a);
        repeat (130) cycle(1'b0, 8'h00, 1'b0, a);
        // randomized traffic
        for (int i = 0; i < 2000; i++) cycle($urandom_range(0, 3) == 0, 8'($urandom), 1'b0, a);
        repeat (100) cycle(1'b0, 8'h00, 1'b0, a);
        check("scoreboard_empty", sb.size(), 0);
        // reset during data bit 3 with a byte queued
        cycle(1'b1, 8'hC3, 1'b0, a);
        s = sb[sb.size()-1].start;
        a = 1'b0;
        for (int i = 0; i < 10 && !a; i++) cycle(1'b1, 8'h99, 1'b0, a);
        while (cyc < s + 4 * CPB + 1) cycle(1'b0, 8'h00, 1'b0, a);
        mon_en = 1'b0;
        check("pre_reset_bit3", tx, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, a);
        check("midreset_tx", tx, 1'b1);
        bad = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (tx !== 1'b1) bad++;
            cycle(1'b0, 8'h00, 1'b0, a);
        end
        check("after_reset_line_idle", bad, 0);
        // minimum bit period on the second instance
        bus2.data_valid = 1'b1;
        bus2.data_in = 8'h80;
        @(negedge clk);
        bus2.data_valid = 1'b0;
        check("cpb2_accept_tx", tx2, 1'b1);
        check("cpb2_accept_ready", bus2.data_ready, 1'b0);
        check("cpb2_accept_busy", busy2, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            got2[k] = tx2;
            exp2[k] = exp_bit(8'h80, k, 2);
            if (k == 0) check("cpb2_ready_after_load", bus2.data_ready, 1'b1);
        end
        check("cpb2_frame", got2, exp2);
        check("cpb2_bit7", got2[17:16], 2'b11);
        check("cpb2_stop", got2[19:18], 2'b11);
        check("cpb2_bit6", got2[15:14], 2'b00);
        @(negedge clk);
        check("cpb2_busy_end", busy2, 1'b0);
        check("cpb2_idle_tx", tx2, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
